// File: rtl/snn_pkg.sv
// Shared fp32 constants, field widths and accumulator FSM state encoding.
// Latency: none (declarations only).
// Backpressure: n/a.
package snn_pkg;

    localparam int FP_W     = 32;
    localparam int FP_EXP_W = 8;
    localparam int FP_MAN_W = 23;

    localparam logic [FP_W-1:0] FP_ZERO    = 32'h0000_0000;
    localparam logic [FP_W-1:0] FP_POS_INF = 32'h7F80_0000;
    localparam logic [FP_W-1:0] FP_QNAN    = 32'h7FC0_0000;

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_ACCUM  = 2'd1;
    localparam state_t ST_THRESH = 2'd2;
    localparam state_t ST_EMIT   = 2'd3;

endpackage

// File: rtl/Addition_Subtraction.sv
// Combinational fp32 add/subtract, round-to-nearest-even, subnormals flushed to zero.
// Latency: 0 cycles (pure combinational).
// Backpressure: n/a. exception flags Inf/NaN operands or an overflowing result.
// Ports: a, b (fp32), sub (1 = a-b), result (fp32), exception.
module Addition_Subtraction
    import snn_pkg::*;
(
    input  logic [FP_W-1:0] a,
    input  logic [FP_W-1:0] b,
    input  logic            sub,
    output logic [FP_W-1:0] result,
    output logic            exception
);
    logic [FP_W-1:0]   b_eff, x, y;
    logic              swap, eff_sub, special, sticky, unused_hidden;
    logic [7:0]        d;
    logic [26:0]       mx, my, my_sh, n;
    logic [27:0]       s;
    logic [4:0]        lz;
    logic signed [9:0] e;
    logic [24:0]       m;

    // x always carries the larger magnitude so the exponent difference is non-negative.
    assign b_eff   = {b[31] ^ sub, b[30:0]};
    assign swap    = b_eff[30:0] > a[30:0];
    assign x       = swap ? b_eff : a;
    assign y       = swap ? a : b_eff;
    assign eff_sub = x[31] ^ y[31];
    assign special = (&a[30:23]) | (&b[30:23]);
    assign d       = x[30:23] - y[30:23];
    // Mantissas carry three guard/round/sticky bits below the fraction.
    assign mx = (x[30:23] == 8'd0) ? '0 : {1'b1, x[22:0], 3'b000};
    assign my = (y[30:23] == 8'd0) ? '0 : {1'b1, y[22:0], 3'b000};

    always_comb begin
        sticky = 1'b0;
        my_sh  = my;
        if (d >= 8'd27) begin
            my_sh = {26'b0, |my};
        end else begin
            sticky = |(my & ((27'd1 << d) - 27'd1));
            my_sh  = (my >> d) | {26'b0, sticky};
        end
    end

    assign s = eff_sub ? ({1'b0, mx} - {1'b0, my_sh}) : ({1'b0, mx} + {1'b0, my_sh});

    always_comb begin
        lz = '0;
        for (int i = 0; i < 27; i++)
            if (s[i]) lz = 5'(26 - i);
    end

    always_comb begin
        e = signed'({2'b00, x[30:23]});
        if (s[27]) begin
            n = {s[27:2], s[1] | s[0]};
            e = e + 10'sd1;
        end else begin
            n = s[26:0] << lz;
            e = e - signed'({5'b0, lz});
        end
        m = {1'b0, n[26:3]} + {24'b0, n[2] & (n[1] | n[0] | n[3])};
        if (m[24]) begin
            m = m >> 1;
            e = e + 10'sd1;
        end
    end

    assign unused_hidden = m[23];

    always_comb begin
        exception = 1'b0;
        result    = {x[31], e[7:0], m[22:0]};
        if (special) begin
            exception = 1'b1;
            // NaN dominates the magnitude order, so a NaN operand always lands in x.
            result = ((|x[22:0]) || ((&y[30:23]) && eff_sub)) ? FP_QNAN
                                                              : {x[31], FP_POS_INF[30:0]};
        end else if (s == '0) begin
            result = {x[31] & ~eff_sub, 31'b0};
        end else if (e >= 10'sd255) begin
            exception = 1'b1;
            result    = {x[31], FP_POS_INF[30:0]};
        end else if (e <= 10'sd0) begin
            result = {x[31], 31'b0};
        end
    end

endmodule

// File: rtl/fp32_ge_compare.sv
// Combinational fp32 a >= b; -0 equals +0, any NaN operand gives 0.
// Latency: 0 cycles (pure combinational).
// Backpressure: n/a.
// Ports: a, b (fp32 operands), ge (1 when a >= b).
module fp32_ge_compare
    import snn_pkg::*;
(
    input  logic [FP_W-1:0] a,
    input  logic [FP_W-1:0] b,
    output logic            ge
);
    logic a_nan, b_nan, both_zero;

    assign a_nan     = (&a[FP_W-2 -: FP_EXP_W]) && (|a[FP_MAN_W-1:0]);
    assign b_nan     = (&b[FP_W-2 -: FP_EXP_W]) && (|b[FP_MAN_W-1:0]);
    assign both_zero = (a[FP_W-2:0] == '0) && (b[FP_W-2:0] == '0);

    // Sign-magnitude ordering: magnitude compare flips for negatives.
    always_comb begin
        ge = 1'b0;
        if (a_nan || b_nan)          ge = 1'b0;
        else if (both_zero)          ge = 1'b1;
        else if (a[FP_W-1] != b[FP_W-1]) ge = b[FP_W-1];
        else if (!a[FP_W-1])         ge = (a[FP_W-2:0] >= b[FP_W-2:0]);
        else                         ge = (a[FP_W-2:0] <= b[FP_W-2:0]);
    end

endmodule

// File: rtl/potential_accumulator.sv
// Per-neuron fp32 membrane integrator: load decayed potential, add weights, threshold, emit.
// Latency: decay_valid -> weight_ready 1 cycle; step_end -> new_valid/spike 2 cycles.
// Backpressure: weight_ready high only in ACCUM, one weight per cycle; no stall on outputs.
// Ports: CLK, RST_N (async low); decay_valid/decay_potential in; weight_valid/weight/weight_ready
//        handshake; step_end pulse; new_valid/new_potential/spike out; err sticky adder exception.
// Build option: REFRACTORY_EN blocks firing and discards weights for REFRAC_STEPS steps after a spike.
module potential_accumulator
    import snn_pkg::*;
#(
    parameter logic [31:0] V_THRESH     = 32'h41F0_0000,
    parameter logic [31:0] V_RESET      = 32'h0000_0000,
    parameter int          REFRAC_STEPS = 2
) (
    input  logic            CLK,
    input  logic            RST_N,
    input  logic            decay_valid,
    input  logic [FP_W-1:0] decay_potential,
    input  logic            weight_valid,
    input  logic [FP_W-1:0] weight,
    output logic            weight_ready,
    input  logic            step_end,
    output logic            new_valid,
    output logic [FP_W-1:0] new_potential,
    output logic            spike,
    output logic            err
);
    state_t          state_q, state_d;
    logic [FP_W-1:0] acc_q, new_pot_q, add_sum;
    logic            add_exc, ge_thresh, fire, fire_q, err_q, xfer, refrac_block;

    assign xfer = weight_valid && weight_ready;

    Addition_Subtraction u_add (
        .a         (acc_q),
        .b         (weight),
        .sub       (1'b0),
        .result    (add_sum),
        .exception (add_exc)
    );

    fp32_ge_compare u_ge (
        .a  (acc_q),
        .b  (V_THRESH),
        .ge (ge_thresh)
    );

`ifdef REFRACTORY_EN
    localparam int CW = (REFRAC_STEPS > 0) ? $clog2(REFRAC_STEPS + 1) : 1;
    logic [CW-1:0] refrac_cnt;

    // Loaded at the emit of a firing step, counts down one per following emit.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            refrac_cnt <= '0;
        end else if (state_q == ST_EMIT) begin
            if (fire_q)                refrac_cnt <= CW'(REFRAC_STEPS);
            else if (refrac_cnt != '0) refrac_cnt <= refrac_cnt - CW'(1);
        end
    end

    assign refrac_block = (refrac_cnt != '0);
`else
    logic unused_refrac;
    assign unused_refrac = (REFRAC_STEPS == 0);
    assign refrac_block  = 1'b0;
`endif

    assign fire = ge_thresh && !refrac_block;

    // State register
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (decay_valid) state_d = ST_ACCUM;
            ST_ACCUM:  if (step_end)    state_d = ST_THRESH;
            ST_THRESH: state_d = ST_EMIT;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        weight_ready  = (state_q == ST_ACCUM);
        new_valid     = (state_q == ST_EMIT);
        spike         = (state_q == ST_EMIT) && fire_q;
        new_potential = new_pot_q;
        err           = err_q;
    end

    // Datapath. A weight accepted alongside step_end is still summed.
    // An exceptional sum is dropped but the handshake completes.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            acc_q     <= V_RESET;
            new_pot_q <= '0;
            fire_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: if (decay_valid) acc_q <= decay_potential;
                ST_ACCUM: begin
                    if (xfer && !refrac_block) begin
                        if (add_exc) err_q <= 1'b1;
                        else         acc_q <= add_sum;
                    end
                end
                ST_THRESH: begin
                    fire_q    <= fire;
                    new_pot_q <= fire ? V_RESET : acc_q;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_potential_accumulator.sv
// Bench for potential_accumulator: directed + randomized timesteps vs a real-arithmetic model.
// Latency: checks new_valid exactly 2 cycles after step_end.
// Backpressure: weights offered with random gaps; weight_ready expected only while accumulating.
module tb_potential_accumulator;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic        decay_valid;
    logic [31:0] decay_potential;
    logic        weight_valid;
    logic [31:0] weight;
    logic        weight_ready;
    logic        step_end;
    logic        new_valid;
    logic [31:0] new_potential;
    logic        spike;
    logic        err;

    always #5 CLK = ~CLK;

    potential_accumulator dut (
        .CLK             (CLK),
        .RST_N           (RST_N),
        .decay_valid     (decay_valid),
        .decay_potential (decay_potential),
        .weight_valid    (weight_valid),
        .weight          (weight),
        .weight_ready    (weight_ready),
        .step_end        (step_end),
        .new_valid       (new_valid),
        .new_potential   (new_potential),
        .spike           (spike),
        .err             (err)
    );

    int          n_chk  = 0;
    int          n_pass = 0;
    bit          m_err;
    int          m_refrac;
    logic [31:0] m_newpot;
    logic [31:0] wq[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_chk++;
        if (obs === expv) n_pass++;
        else $display("FAIL %s: got %h want %h", tag, obs, expv);
    endtask

    function automatic real f2r(input logic [31:0] f);
        logic [10:0] e;
        if (f[30:23] == 8'd0) return 0.0;
        e = {3'b000, f[30:23]} + 11'd896;
        return $bitstoreal({f[31], e, f[22:0], 29'b0});
    endfunction

    // Only used for values exactly representable in fp32.
    function automatic logic [31:0] r2f(input real r);
        logic [63:0] b;
        logic [10:0] e;
        if (r == 0.0) return 32'h0;
        b = $realtobits(r);
        e = b[62:52] - 11'd896;
        return {b[63], e[7:0], b[51:29]};
    endfunction

    // One timestep: load base, send wq, close the step, check the emitted result.
    task automatic run_step(input logic [31:0] base, input bit merge_end, input string tag);
        real         acc;
        bit          blocked;
        bit          fire;
        logic [31:0] exp_pot;
        acc     = f2r(base);
        blocked = 1'b0;
`ifdef REFRACTORY_EN
        blocked = (m_refrac > 0);
`endif
        foreach (wq[i]) begin
            if (!blocked) begin
                if (wq[i][30:23] == 8'hFF) m_err = 1'b1;
                else acc = acc + f2r(wq[i]);
            end
        end
        fire    = !blocked && (acc >= 30.0);
        exp_pot = fire ? 32'h0 : r2f(acc);
`ifdef REFRACTORY_EN
        if (fire) m_refrac = 2;
        else if (m_refrac > 0) m_refrac--;
`endif

        @(negedge CLK);
        decay_valid     = 1'b1;
        decay_potential = base;
        @(negedge CLK);
        decay_valid     = 1'b0;
        decay_potential = $urandom;
        chk({tag, " ready"}, weight_ready, 1);
        foreach (wq[i]) begin
            repeat ($urandom_range(0, 2)) begin
                decay_valid = 1'($urandom_range(0, 1));
                @(negedge CLK);
            end
            decay_valid  = 1'b0;
            weight_valid = 1'b1;
            weight       = wq[i];
            if (merge_end && i == wq.size() - 1) step_end = 1'b1;
            @(negedge CLK);
            weight_valid = 1'b0;
        end
        decay_valid = 1'b0;
        if (!merge_end || wq.size() == 0) begin
            step_end = 1'b1;
            @(negedge CLK);
        end
        step_end = 1'b0;
        chk({tag, " thresh nv"}, new_valid, 0);
        chk({tag, " thresh rdy"}, weight_ready, 0);
        @(negedge CLK);
        chk({tag, " emit nv"}, new_valid, 1);
        chk({tag, " spike"}, spike, fire);
        chk({tag, " potential"}, new_potential, exp_pot);
        chk({tag, " err"}, err, m_err);
        @(negedge CLK);
        chk({tag, " post nv"}, new_valid, 0);
        chk({tag, " post spike"}, spike, 0);
        chk({tag, " hold"}, new_potential, exp_pot);
        m_newpot = exp_pot;
    endtask

    initial begin
        RST_N           = 1'b0;
        decay_valid     = 1'b0;
        decay_potential = '0;
        weight_valid    = 1'b0;
        weight          = '0;
        step_end        = 1'b0;
        m_err           = 1'b0;
        m_refrac        = 0;
        m_newpot        = '0;
        #12;
        chk("rst ready", weight_ready, 0);
        chk("rst nv", new_valid, 0);
        chk("rst spike", spike, 0);
        chk("rst err", err, 0);
        chk("rst pot", new_potential, 0);
        @(negedge CLK);
        RST_N = 1'b1;

        // 10 + 5 + 5 = 20, below threshold
        wq = '{32'h40A00000, 32'h40A00000};
        run_step(32'h41200000, 1'b0, "t1");
        chk("t1 value", m_newpot, 32'h41A00000);

        // ~27.86 + 3 crosses 30
        wq = '{32'h40400000};
        run_step(32'h41DED852, 1'b0, "t2");

        // weight of exactly 30 accepted in the step_end cycle
        wq = '{32'h41F00000};
        run_step(32'h00000000, 1'b1, "t3");

        // weights and step_end while idle
        @(negedge CLK);
        weight_valid = 1'b1;
        weight       = 32'h41F00000;
        step_end     = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge CLK);
            chk("idle ready", weight_ready, 0);
            chk("idle nv", new_valid, 0);
        end
        weight_valid = 1'b0;
        step_end     = 1'b0;
        chk("idle hold", new_potential, m_newpot);

        // +Inf weight dropped, err sticky, rest sums to 13
        wq = '{32'h40000000, 32'h7F800000, 32'h3F800000};
        run_step(32'h41200000, 1'b0, "t5");
        chk("t5 value", m_newpot, 32'h41500000);

        // randomized timesteps on a quarter-unit grid (exact in fp32)
        for (int s = 0; s < 25; s++) begin
            wq.delete();
            repeat ($urandom_range(0, 5))
                wq.push_back(r2f((real'($urandom_range(0, 64)) - 32.0) / 4.0));
            run_step(r2f(real'($urandom_range(0, 160)) / 4.0), 1'($urandom_range(0, 1)), "rnd");
        end

        // asynchronous reset while accumulating
        @(negedge CLK);
        decay_valid     = 1'b1;
        decay_potential = 32'h41200000;
        @(negedge CLK);
        decay_valid  = 1'b0;
        weight_valid = 1'b1;
        weight       = 32'h40A00000;
        #2;
        RST_N = 1'b0;
        #1;
        chk("mid rst ready", weight_ready, 0);
        chk("mid rst nv", new_valid, 0);
        chk("mid rst spike", spike, 0);
        chk("mid rst err", err, 0);
        chk("mid rst pot", new_potential, 0);
        weight_valid = 1'b0;
        @(negedge CLK);
        chk("mid rst nv2", new_valid, 0);
        RST_N    = 1'b1;
        m_err    = 1'b0;
        m_refrac = 0;
        m_newpot = '0;

        // repeated over-threshold steps (refractory window when enabled)
        for (int s = 0; s < 4; s++) begin
            wq = '{32'h3F800000};
            run_step(32'h420C0000, 1'b0, "refrac");
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
